// File: rtl/axis_ipg_shaper_if.sv
// axis_ipg_shaper_if: AXI-Stream bundle (tdata/tstrb/tuser/tvalid/tlast/tready) for the IPG shaper ports.
interface axis_ipg_shaper_if #(
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (
        output tdata, tstrb, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tuser, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/axis_ipg_shaper.sv
// axis_ipg_shaper: holds each packet's first beat until its TUSER delay has elapsed since the previous SOP.
// Define IPG_SHAPER_STATS_EN to build the pkt_cnt / hold_cycles counters; otherwise they read as zero.
module axis_ipg_shaper #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int DELAY_LSB            = 32,
    parameter int DELAY_WIDTH          = 32
) (
    input  logic              axi_aclk,
    input  logic              sw_rst,
    input  logic              shape_en,
    axis_ipg_shaper_if.slave  s_axis,
    axis_ipg_shaper_if.master m_axis,
    output logic [31:0]       pkt_cnt,
    output logic [31:0]       hold_cycles
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        PASS = 2'd2
    } state_t;

    localparam logic [DELAY_WIDTH-1:0] GAP_ONE = {{(DELAY_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state;
    logic [DELAY_WIDTH-1:0] gap_cnt;
    logic [DELAY_WIDTH-1:0] delay;
    logic                   sop_wait;
    logic                   gate;
    logic                   handshake;

    // IDLE and HOLD both mean the current beat is a SOP waiting on its gap.
    assign delay     = s_axis.tuser[DELAY_LSB +: DELAY_WIDTH];
    assign sop_wait  = (state != PASS);
    assign gate      = !sop_wait || !shape_en || (gap_cnt >= delay);
    assign handshake = s_axis.tvalid && m_axis.tready && gate;

    assign m_axis.tdata  = s_axis.tdata;
    assign m_axis.tstrb  = s_axis.tstrb;
    assign m_axis.tuser  = s_axis.tuser;
    assign m_axis.tlast  = s_axis.tlast;
    assign m_axis.tvalid = s_axis.tvalid && gate;
    assign s_axis.tready = m_axis.tready && gate;

    always_ff @(posedge axi_aclk) begin
        if (sw_rst) begin
            state   <= IDLE;
            gap_cnt <= '1;
        end else begin
            if (sop_wait && handshake)
                gap_cnt <= GAP_ONE;
            else if (gap_cnt != '1)
                gap_cnt <= gap_cnt + GAP_ONE;

            unique case (state)
                IDLE: begin
                    if (handshake)
                        state <= s_axis.tlast ? IDLE : PASS;
                    else if (s_axis.tvalid && !gate)
                        state <= HOLD;
                end
                HOLD: begin
                    if (handshake)
                        state <= s_axis.tlast ? IDLE : PASS;
                end
                PASS: begin
                    if (handshake && s_axis.tlast)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IPG_SHAPER_STATS_EN
    // hold_cycles counts the cycles in which the gate is actually blocking a waiting SOP.
    always_ff @(posedge axi_aclk) begin
        if (sw_rst) begin
            pkt_cnt     <= '0;
            hold_cycles <= '0;
        end else begin
            if (handshake && s_axis.tlast)
                pkt_cnt <= pkt_cnt + 32'd1;
            if (sop_wait && s_axis.tvalid && !gate && (hold_cycles != '1))
                hold_cycles <= hold_cycles + 32'd1;
        end
    end
`else
    assign pkt_cnt     = '0;
    assign hold_cycles = '0;
`endif
endmodule

// File: tb/tb_axis_ipg_shaper.sv
// tb_axis_ipg_shaper: directed and randomized stimulus against a cycle-timestamp model of the IPG shaper.
module tb_axis_ipg_shaper;
    typedef struct {
        logic [255:0] data;
        logic [31:0]  strb;
        logic [127:0] user;
        logic         last;
    } beat_t;

    logic        axi_aclk = 1'b0;
    logic        sw_rst   = 1'b1;
    logic        shape_en = 1'b1;
    logic [31:0] pkt_cnt;
    logic [31:0] hold_cycles;
    int          cyc = 0;

    axis_ipg_shaper_if #(.DATA_WIDTH(256), .USER_WIDTH(128)) s_if ();
    axis_ipg_shaper_if #(.DATA_WIDTH(256), .USER_WIDTH(128)) m_if ();

    axis_ipg_shaper #(
        .C_S_AXIS_DATA_WIDTH (256),
        .C_S_AXIS_TUSER_WIDTH(128),
        .DELAY_LSB           (32),
        .DELAY_WIDTH         (32)
    ) dut (
        .axi_aclk   (axi_aclk),
        .sw_rst     (sw_rst),
        .shape_en   (shape_en),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .pkt_cnt    (pkt_cnt),
        .hold_cycles(hold_cycles)
    );

    always #5 axi_aclk = ~axi_aclk;
    always @(posedge axi_aclk) cyc <= cyc + 1;

    int    total = 0;
    int    bad   = 0;
    beat_t srcQ[$];
    bit    srcValid = 0;
    int    validPct = 100;
    int    readyPct = 100;
    int    togglePct = 0;
    bit    stallOn = 0;
    int    dutSop[$];

    // Reference model: packet boundary, timestamp of the last SOP handshake, expected counters.
    bit          inPkt = 0;
    bit          haveSop = 0;
    int          lastSop = 0;
    logic [31:0] expPkt = 0;
    logic [31:0] expHold = 0;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] statsExp(input logic [31:0] v);
`ifdef IPG_SHAPER_STATS_EN
        return v;
`else
        return (v & 32'd0);
`endif
    endfunction

    function automatic beat_t randBeat();
        beat_t b;
        for (int i = 0; i < 8; i++) b.data[i*32 +: 32] = $urandom;
        for (int i = 0; i < 4; i++) b.user[i*32 +: 32] = $urandom;
        b.strb = $urandom;
        b.last = 1'($urandom_range(1));
        return b;
    endfunction

    task automatic queuePacket(input int len, input logic [31:0] delay);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b = randBeat();
            b.user[63:32] = delay;
            b.last = (i == len - 1);
            srcQ.push_back(b);
        end
    endtask

    // One clock cycle: drive after the edge, check at the falling edge, then advance the model.
    task automatic applyStimulus(input bit doReset);
        beat_t       b;
        logic [31:0] since;
        bit          expGate;
        bit          hs;
        @(posedge axi_aclk);
        #1;
        sw_rst = doReset;
        if (!srcValid && srcQ.size() > 0 && $urandom_range(99) < validPct) srcValid = 1;
        b = srcValid ? srcQ[0] : randBeat();
        s_if.tdata  = b.data;
        s_if.tstrb  = b.strb;
        s_if.tuser  = b.user;
        s_if.tlast  = b.last;
        s_if.tvalid = srcValid;
        since = 32'(cyc - lastSop);
        if (stallOn && haveSop && since >= 45 && since <= 60)
            m_if.tready = 1'b0;
        else
            m_if.tready = ($urandom_range(99) < readyPct);
        if (togglePct > 0 && $urandom_range(99) < togglePct) shape_en = !shape_en;

        @(negedge axi_aclk);
        expGate = inPkt || !haveSop || !shape_en || (since >= b.user[63:32]);
        checkOutput("m_tvalid", m_if.tvalid, srcValid && expGate);
        checkOutput("s_tready", s_if.tready, m_if.tready && expGate);
        checkOutput("m_tdata", m_if.tdata, b.data);
        checkOutput("m_tstrb", m_if.tstrb, b.strb);
        checkOutput("m_tuser", m_if.tuser, b.user);
        checkOutput("m_tlast", m_if.tlast, b.last);
        checkOutput("pkt_cnt", pkt_cnt, statsExp(expPkt));
        checkOutput("hold_cycles", hold_cycles, statsExp(expHold));

        hs = srcValid && s_if.tready;
        if (hs && !inPkt) dutSop.push_back(cyc);
        if (doReset) begin
            inPkt = 0;
            haveSop = 0;
            expPkt = 0;
            expHold = 0;
        end else begin
            if (!inPkt && srcValid && !expGate && expHold != 32'hFFFF_FFFF) expHold++;
            if (hs) begin
                if (!inPkt) begin
                    lastSop = cyc;
                    haveSop = 1;
                end
                inPkt = !b.last;
                if (b.last) expPkt++;
            end
        end
        if (hs) begin
            void'(srcQ.pop_front());
            srcValid = 0;
        end
    endtask

    task automatic runUntilDrained(input string tag, input int budget);
        int n = 0;
        while ((srcQ.size() > 0 || srcValid) && n < budget) begin
            applyStimulus(1'b0);
            n++;
        end
        if (srcQ.size() > 0 || srcValid) checkOutput({tag, "_timeout"}, 1, 0);
    endtask

    task automatic applyReset();
        srcQ.delete();
        srcValid = 0;
        applyStimulus(1'b1);
        dutSop.delete();
    endtask

    initial begin
        int rc;
        s_if.tdata  = '0;
        s_if.tstrb  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        repeat (2) @(posedge axi_aclk);

        // Reset state: counters cleared and gap saturated so even the largest delay is satisfied.
        #1;
        s_if.tvalid = 1'b1;
        s_if.tuser[63:32] = 32'hFFFF_FFFF;
        @(negedge axi_aclk);
        checkOutput("rst_pkt_cnt", pkt_cnt, 0);
        checkOutput("rst_hold_cycles", hold_cycles, 0);
        checkOutput("rst_gate_open", s_if.tready, 1);
        s_if.tvalid = 1'b0;

        $display("[TB] three 2-beat packets, D=10");
        applyReset();
        for (int i = 0; i < 3; i++) queuePacket(2, 10);
        runUntilDrained("s1", 200);
        applyStimulus(1'b0);
        checkOutput("s1_sop_count", dutSop.size(), 3);
        if (dutSop.size() >= 3) begin
            checkOutput("s1_gap0", dutSop[1] - dutSop[0], 10);
            checkOutput("s1_gap1", dutSop[2] - dutSop[1], 10);
        end
        checkOutput("s1_pkt_cnt", pkt_cnt, statsExp(3));
        checkOutput("s1_hold_cycles", hold_cycles, statsExp(16));

        $display("[TB] 12-beat packet then 1-beat packet, D=5");
        applyReset();
        queuePacket(12, 5);
        queuePacket(1, 5);
        runUntilDrained("s2", 200);
        applyStimulus(1'b0);
        checkOutput("s2_sop_count", dutSop.size(), 2);
        if (dutSop.size() >= 2) checkOutput("s2_gap", dutSop[1] - dutSop[0], 12);
        checkOutput("s2_hold_cycles", hold_cycles, 0);

        $display("[TB] shaping disabled, D=1000");
        shape_en = 1'b0;
        applyReset();
        for (int i = 0; i < 4; i++) queuePacket(2, 1000);
        runUntilDrained("s3", 200);
        applyStimulus(1'b0);
        checkOutput("s3_sop_count", dutSop.size(), 4);
        for (int i = 1; i < dutSop.size(); i++) checkOutput("s3_gap", dutSop[i] - dutSop[i-1], 2);
        checkOutput("s3_hold_cycles", hold_cycles, 0);
        shape_en = 1'b1;

        $display("[TB] downstream stall across the release point, D=50");
        applyReset();
        stallOn = 1;
        queuePacket(2, 0);
        queuePacket(2, 50);
        runUntilDrained("s4", 300);
        stallOn = 0;
        checkOutput("s4_sop_count", dutSop.size(), 2);
        if (dutSop.size() >= 2) checkOutput("s4_gap", dutSop[1] - dutSop[0], 61);

        $display("[TB] reset during HOLD, D=100");
        applyReset();
        queuePacket(1, 0);
        queuePacket(2, 100);
        repeat (20) applyStimulus(1'b0);
        checkOutput("s5_held_ready", s_if.tready, 0);
        applyStimulus(1'b1);
        rc = cyc;
        applyStimulus(1'b0);
        checkOutput("s5_pkt_after_rst", pkt_cnt, 0);
        checkOutput("s5_hold_after_rst", hold_cycles, 0);
        runUntilDrained("s5", 50);
        checkOutput("s5_sop_count", dutSop.size(), 2);
        if (dutSop.size() >= 2) checkOutput("s5_sop_cycle", dutSop[1], rc + 1);

        $display("[TB] randomized traffic with shape_en toggling");
        applyReset();
        validPct = 70;
        readyPct = 80;
        togglePct = 3;
        for (int i = 0; i < 40; i++) queuePacket($urandom_range(5, 1), $urandom_range(15));
        runUntilDrained("s6", 5000);
        checkOutput("s6_sop_count", dutSop.size(), 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_ipg_shaper.md
# axis_ipg_shaper

Inter-packet-gap shaper on the pcap replay transmit path, directly downstream of the FIFO-to-AXI-Stream unpacker. It holds off the first beat of each packet until a per-packet delay, carried in TUSER, has elapsed since the previous packet's first beat. It then passes the packet through unchanged. This reproduces captured inter-arrival timing at the output port.

## Interface
- C_S_AXIS_DATA_WIDTH, 256, TDATA width (input and output)
- C_S_AXIS_TUSER_WIDTH, 128, TUSER width (input and output)
- DELAY_LSB, 32, bit position of the delay field within TUSER
- DELAY_WIDTH, 32, delay field width, in axi_aclk cycles
- axi_aclk  in  1  sole clock
- sw_rst  in  1  synchronous, active-high reset
- shape_en  in  1  1 = enforce delays; 0 = transparent pass-through
- s_axis_tdata/tstrb/tuser/tvalid/tlast  in  256/32/128/1/1  upstream stream
- s_axis_tready  out  1  upstream ready
- m_axis_tdata/tstrb/tuser/tvalid/tlast  out  256/32/128/1/1  downstream stream
- m_axis_tready  in  1  downstream ready
- pkt_cnt  out  32  packets forwarded; counts tlast handshakes
- hold_cycles  out  32  cycles spent in HOLD, saturating

## Operation
- Datapath is zero-latency: m_axis_tdata, tstrb, tuser and tlast equal the corresponding s_axis_* signals at all times.
- A gate signal controls flow:
  - m_axis_tvalid = s_axis_tvalid & gate
  - s_axis_tready = m_axis_tready & gate
- The beat after reset, and the beat after any tlast handshake, is a SOP (start of packet) beat.
- Delay D = s_axis_tuser[DELAY_LSB +: DELAY_WIDTH], sampled only on a SOP beat while s_axis_tvalid = 1.
- gap_cnt is DELAY_WIDTH bits wide:
  - set to all-ones on reset
  - set to 1 in the cycle after a SOP handshake
  - otherwise increments each cycle, saturating at all-ones
- States:
  - IDLE (awaiting SOP): gate = (!shape_en) | (gap_cnt >= D).
    - Valid SOP and gate = 0: go to HOLD.
    - SOP handshake with tlast = 0: go to PASS.
    - SOP handshake with tlast = 1: stay in IDLE.
  - HOLD: gate = (!shape_en) | (gap_cnt >= D); D is re-read from s_axis_tuser, which is stable under AXIS rules.
    - Once gate = 1: handshake proceeds when m_axis_tready = 1.
    - Then go to PASS, or to IDLE if that beat carries tlast.
  - PASS: gate = 1; on a tlast handshake go to IDLE.
- If D ≤ gap_cnt (packet longer than D, or D = 0 or 1), no hold is added. The shaper only delays; it never compresses gaps.
- shape_en only affects the gate. gap_cnt keeps tracking whether shape_en is 0 or 1.

## Timing
- Reset values: state IDLE, gap_cnt all-ones, pkt_cnt 0, hold_cycles 0.
- m_axis_tvalid and s_axis_tready follow their inputs combinationally through the gate.
- SOP spacing: a SOP handshake at cycle t is followed by the next SOP handshake no earlier than t + D, where D is the next packet's delay. Handshakes occur exactly at t + D when upstream and downstream are both ready.
- The first packet after reset passes with no hold.
- shape_en falling during HOLD: the gate opens in the same cycle.
- shape_en rising during PASS: no effect until the next SOP.
- Reset mid-packet: the remainder of that packet is treated as a new SOP. Clearing upstream is the integrator's responsibility.
- hold_cycles increments in every cycle where state is HOLD, or state is IDLE with a valid SOP and gate = 0.

## Configuration
- IPG_SHAPER_STATS_EN defined: pkt_cnt and hold_cycles are implemented as described. pkt_cnt wraps modulo 2^32; hold_cycles saturates at all-ones.
- IPG_SHAPER_STATS_EN undefined: pkt_cnt and hold_cycles are tied to 0 and no counter logic is generated. Shaping behaviour is identical.

## Test plan
- Three 2-beat packets with D = 10, m_axis_tready = 1, upstream always valid → SOP handshakes at cycles t, t+10, t+20; pkt_cnt = 3; hold_cycles = 16.
- 12-beat packet followed by a 1-beat packet with D = 5 → second SOP handshakes at t+12 with no hold; hold_cycles unchanged.
- shape_en = 0 with D = 1000 on every packet → back-to-back throughput; hold_cycles = 0.
- D = 50, downstream drops tready for cycles 45–60 after the previous SOP → SOP transfers at the first ready cycle (t+61); tdata/tuser unchanged while stalled.
- sw_rst asserted during HOLD with D = 100 → next cycle state is IDLE; the pending beat transfers immediately after reset (gap_cnt saturated); counters are 0.
- Built without IPG_SHAPER_STATS_EN, rerun the first scenario → identical SOP timing; pkt_cnt = hold_cycles = 0.
